bolucu: RTL and testbench
=========================

// Module: bolucu
// PURPOSE
//  Iterative radix-2 restoring integer divider. It is the counterpart of the
//  single-cycle multiplier and completes the M-extension datapath
//  (DIV/DIVU/REM/REMU). Operands enter through a valid/ready request port;
//  quotient and remainder leave through a valid/ready result port.
//  Multi-cycle: one quotient bit is produced per clock.
// PARAMETERS
//  XLEN      32   operand, quotient and remainder width
//  SAYAC_W   6    iteration counter width, equal to clog2(XLEN)+1
// PORTS
//  clk_i             in   1     clock, rising edge
//  rstn_i            in   1     asynchronous reset, active-low
//  istek_gecerli_i   in   1     request valid
//  istek_hazir_o     out  1     request ready; high only in BOSTA
//  bolunen_i         in   XLEN  dividend
//  bolunen_isaretli_i in  1     treat the dividend as two's complement
//  bolen_i           in   XLEN  divisor
//  bolen_isaretli_i  in   1     treat the divisor as two's complement
//  iptal_i           in   1     flush: abort the current operation and drop any held result
//  sonuc_gecerli_o   out  1     result valid
//  sonuc_hazir_i     in   1     result consumer ready
//  bolum_o           out  XLEN  quotient
//  kalan_o           out  XLEN  remainder
// BEHAVIOUR
//  Clock and reset: one clock (clk_i). Reset rstn_i is asynchronous, active-low.
//  Reset (async, any state): state=BOSTA, counter=0, all datapath registers=0.
//    istek_hazir_o=1, sonuc_gecerli_o=0, bolum_o=0, kalan_o=0.
//  Request handshake
//    - A request is accepted when istek_gecerli_i && istek_hazir_o (cycle N).
//    - Operands and sign flags are captured only at acceptance.
//  States
//    - BOSTA -> BOL: normal operation.
//    - BOSTA -> SONUC: special case (see below).
//    - BOL -> DUZELT: after XLEN iterations.
//    - DUZELT -> SONUC.
//    - SONUC -> BOSTA: when sonuc_hazir_i=1.
//  Capture (at acceptance)
//    - neg_a = bolunen_i[XLEN-1] && bolunen_isaretli_i
//    - neg_b = bolen_i[XLEN-1] && bolen_isaretli_i
//    - Magnitudes are stored in two's-complement-negated form when neg_x=1.
//    - Partial remainder R=0; quotient shift register Q = |dividend|.
//  BOL (per cycle)
//    - T = {R[XLEN-1:0],Q[XLEN-1]} - {1'b0,|divisor|}, computed at XLEN+1 bits.
//    - If T is non-negative: R=T and shift 1 into Q; otherwise R keeps its
//      shifted value and 0 is shifted into Q.
//    - Exactly XLEN cycles, counted by a counter that starts at 0.
//  DUZELT
//    - Quotient is negated if neg_a^neg_b.
//    - Remainder is negated if neg_a (the remainder takes the dividend's sign).
//    - Results are registered into bolum_o and kalan_o.
//  Latency
//    - Normal path: sonuc_gecerli_o rises at N+XLEN+2 (34 cycles for XLEN=32).
//    - Special path: sonuc_gecerli_o rises at N+1.
//  Special cases (decided at acceptance, BOL skipped)
//    - Divide by zero (bolen_i==0): bolum_o=all ones; kalan_o=bolunen_i unchanged.
//    - Signed overflow (both sign flags set, bolunen_i=0x80000000, bolen_i=all
//      ones): bolum_o=0x80000000; kalan_o=0.
//  Result handshake
//    - In SONUC, sonuc_gecerli_o=1 and bolum_o/kalan_o stay stable until
//      sonuc_hazir_i=1.
//    - sonuc_gecerli_o drops in the next cycle.
//    - istek_hazir_o rises one cycle after the result handshake. There is no
//      same-cycle back-to-back acceptance.
//  iptal_i
//    - Has priority over every other event in all states.
//    - Next state is BOSTA, sonuc_gecerli_o=0 from the next cycle, any result is
//      discarded, and bolum_o/kalan_o keep their old values.
//    - If iptal_i && istek_gecerli_i in BOSTA, the request is NOT accepted.
//  Mixed sign flags are legal; each operand is interpreted independently.
//  Outputs are registered; there are no combinational paths from input to output.
// STRUCTURE
//  - Shared package: state encoding constants (BOSTA, BOL, DUZELT, SONUC) and
//    the XLEN constant. The multiplier uses the same package.
//  - Subtractor: an XLEN+1 bit 'toplayici' instance, with ~|divisor| and carry_i=1.
//    No other sub-modules; the FSM and datapath sit in one file.
// TESTING
//  1 Unsigned 100/7: result valid at N+34; bolum_o=14, kalan_o=2.
//  2 Signed -7/2 -> bolum_o=0xFFFFFFFD (-3), kalan_o=0xFFFFFFFF (-1);
//    signed 7/-2 -> -3, 1.
//  3 Division by zero: 0x12345678/0 -> bolum_o=0xFFFFFFFF, kalan_o=0x12345678,
//    result valid at N+1 (for both signed and unsigned).
//  4 Signed 0x80000000/0xFFFFFFFF -> bolum_o=0x80000000, kalan_o=0 at N+1;
//    the same operands unsigned -> bolum_o=0, kalan_o=0x80000000 at N+34.
//  5 Backpressure: sonuc_hazir_i=0 for 10 cycles -> valid and outputs held
//    stable, istek_hazir_o=0; after the handshake, istek_hazir_o=1 one cycle later.
//  6 iptal_i at iteration 15, then rstn_i=0 mid-BOL in a second run
//    -> state BOSTA, sonuc_gecerli_o never rises for the aborted operation;
//    then 0xFFFFFFFF/1 unsigned -> bolum_o=0xFFFFFFFF, kalan_o=0.

Source files
------------

// File: rtl/bolucu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bolucu_pkg
//  Brief    : Shared constants for the M-extension datapath (divider and
//             multiplier): operand width and the divider state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package bolucu_pkg;

    // Default operand width of the integer datapath.
    localparam int c_XLEN    = 32;
    // Iteration counter width, clog2(c_XLEN)+1.
    localparam int c_SAYAC_W = 6;

    // Divider state encoding.
    localparam int         c_DURUM_W = 2;
    localparam logic [1:0] c_BOSTA   = 2'd0;  // idle, accepting requests
    localparam logic [1:0] c_BOL     = 2'd1;  // one quotient bit per clock
    localparam logic [1:0] c_DUZELT  = 2'd2;  // sign correction of results
    localparam logic [1:0] c_SONUC   = 2'd3;  // result presented, waiting for consumer

endpackage : bolucu_pkg
`default_nettype wire

// File: rtl/bolucu_toplayici.sv
`default_nettype none
// ============================================================================
//  Module   : bolucu_toplayici
//  Brief    : Plain W-bit adder with carry-in. The divider feeds it the
//             inverted divisor and carry_i=1 to form a subtraction.
//  Revision : 1.0 - initial release
// ============================================================================
module bolucu_toplayici #(
    parameter int W = 33
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         carry_i,
    output logic [W-1:0] toplam_o
);

    // Sum modulo 2^W; carry-out is not needed by any user.
    assign toplam_o = a_i + b_i + {{(W-1){1'b0}}, carry_i};

endmodule : bolucu_toplayici
`default_nettype wire

// File: rtl/bolucu.sv
`default_nettype none
// ============================================================================
//  Module   : bolucu
//  Brief    : Iterative radix-2 restoring integer divider (DIV/DIVU/REM/REMU).
//             Valid/ready request and result ports, one quotient bit per
//             clock, divide-by-zero and signed overflow resolved at accept.
//  Revision : 1.0 - initial release
// ============================================================================
module bolucu
    import bolucu_pkg::*;
#(
    parameter int XLEN    = c_XLEN,
    parameter int SAYAC_W = c_SAYAC_W
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            istek_gecerli_i,
    output logic            istek_hazir_o,
    input  logic [XLEN-1:0] bolunen_i,
    input  logic            bolunen_isaretli_i,
    input  logic [XLEN-1:0] bolen_i,
    input  logic            bolen_isaretli_i,
    input  logic            iptal_i,
    output logic            sonuc_gecerli_o,
    input  logic            sonuc_hazir_i,
    output logic [XLEN-1:0] bolum_o,
    output logic [XLEN-1:0] kalan_o
);

    localparam logic [XLEN-1:0]    c_EN_KUCUK = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SAYAC_W-1:0] c_SON_TUR  = SAYAC_W'(XLEN - 1);

    logic [c_DURUM_W-1:0] r_durum;
    logic [SAYAC_W-1:0]   r_sayac;
    logic [XLEN-1:0]      r_kalan_ara;   // partial remainder R
    logic [XLEN-1:0]      r_bolum_ara;   // quotient shift register Q
    logic [XLEN-1:0]      r_bolen_mut;   // |divisor|
    logic                 r_neg_a;
    logic                 r_neg_b;
    logic [XLEN-1:0]      r_bolum;
    logic [XLEN-1:0]      r_kalan;

    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_bolunen_mut;
    logic [XLEN-1:0] w_bolen_mut;
    logic            w_kabul;
    logic            w_sifira_bolme;
    logic            w_tasma;
    logic [XLEN:0]   w_fark;

    // Operand sign decode and magnitudes, used only at acceptance.
    assign w_neg_a        = bolunen_i[XLEN-1] & bolunen_isaretli_i;
    assign w_neg_b        = bolen_i[XLEN-1] & bolen_isaretli_i;
    assign w_bolunen_mut  = w_neg_a ? (~bolunen_i + 1'b1) : bolunen_i;
    assign w_bolen_mut    = w_neg_b ? (~bolen_i + 1'b1) : bolen_i;
    assign w_kabul        = istek_gecerli_i & (r_durum == c_BOSTA) & ~iptal_i;
    assign w_sifira_bolme = (bolen_i == '0);
    assign w_tasma        = bolunen_isaretli_i & bolen_isaretli_i &
                            (bolunen_i == c_EN_KUCUK) & (bolen_i == '1);

    // Trial subtraction T = {R, Q[msb]} - |divisor| at XLEN+1 bits.
    bolucu_toplayici #(
        .W (XLEN + 1)
    ) toplayici (
        .a_i      ({r_kalan_ara, r_bolum_ara[XLEN-1]}),
        .b_i      (~{1'b0, r_bolen_mut}),
        .carry_i  (1'b1),
        .toplam_o (w_fark)
    );

    // Control FSM and datapath: capture, iterate, sign-correct, present.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_durum     <= c_BOSTA;
            r_sayac     <= '0;
            r_kalan_ara <= '0;
            r_bolum_ara <= '0;
            r_bolen_mut <= '0;
            r_neg_a     <= 1'b0;
            r_neg_b     <= 1'b0;
            r_bolum     <= '0;
            r_kalan     <= '0;
        end else if (iptal_i) begin
            // Flush wins over everything; output registers keep their values.
            r_durum <= c_BOSTA;
            r_sayac <= '0;
        end else begin
            case (r_durum)
                c_BOSTA: begin
                    if (w_kabul) begin
                        r_neg_a     <= w_neg_a;
                        r_neg_b     <= w_neg_b;
                        r_kalan_ara <= '0;
                        r_bolum_ara <= w_bolunen_mut;
                        r_bolen_mut <= w_bolen_mut;
                        r_sayac     <= '0;
                        if (w_sifira_bolme) begin
                            r_bolum <= '1;
                            r_kalan <= bolunen_i;
                            r_durum <= c_SONUC;
                        end else if (w_tasma) begin
                            r_bolum <= c_EN_KUCUK;
                            r_kalan <= '0;
                            r_durum <= c_SONUC;
                        end else begin
                            r_durum <= c_BOL;
                        end
                    end
                end
                c_BOL: begin
                    // Sign bit of T clear means the divisor fits: keep T.
                    if (!w_fark[XLEN]) begin
                        r_kalan_ara <= w_fark[XLEN-1:0];
                    end else begin
                        r_kalan_ara <= {r_kalan_ara[XLEN-2:0], r_bolum_ara[XLEN-1]};
                    end
                    r_bolum_ara <= {r_bolum_ara[XLEN-2:0], ~w_fark[XLEN]};
                    if (r_sayac == c_SON_TUR) begin
                        r_sayac <= '0;
                        r_durum <= c_DUZELT;
                    end else begin
                        r_sayac <= r_sayac + 1'b1;
                    end
                end
                c_DUZELT: begin
                    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
                    r_bolum <= (r_neg_a ^ r_neg_b) ? (~r_bolum_ara + 1'b1) : r_bolum_ara;
                    r_kalan <= r_neg_a ? (~r_kalan_ara + 1'b1) : r_kalan_ara;
                    r_durum <= c_SONUC;
                end
                c_SONUC: begin
                    if (sonuc_hazir_i) begin
                        r_durum <= c_BOSTA;
                    end
                end
                default: begin
                    r_durum <= c_BOSTA;
                end
            endcase
        end
    end

    // Handshake flags decode directly from the state register.
    assign istek_hazir_o   = (r_durum == c_BOSTA);
    assign sonuc_gecerli_o = (r_durum == c_SONUC);
    assign bolum_o         = r_bolum;
    assign kalan_o         = r_kalan;

endmodule : bolucu
`default_nettype wire

// File: tb/tb_bolucu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bolucu
//  Brief    : Self-checking bench for bolucu: directed corner cases plus
//             randomized operands against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bolucu;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rstn_i;
    logic            istek_gecerli_i;
    logic            istek_hazir_o;
    logic [XLEN-1:0] bolunen_i;
    logic            bolunen_isaretli_i;
    logic [XLEN-1:0] bolen_i;
    logic            bolen_isaretli_i;
    logic            iptal_i;
    logic            sonuc_gecerli_o;
    logic            sonuc_hazir_i;
    logic [XLEN-1:0] bolum_o;
    logic [XLEN-1:0] kalan_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_q;
    logic [31:0] last_r;

    always #5 clk_i = ~clk_i;

    bolucu #(
        .XLEN    (32),
        .SAYAC_W (6)
    ) dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .istek_gecerli_i    (istek_gecerli_i),
        .istek_hazir_o      (istek_hazir_o),
        .bolunen_i          (bolunen_i),
        .bolunen_isaretli_i (bolunen_isaretli_i),
        .bolen_i            (bolen_i),
        .bolen_isaretli_i   (bolen_isaretli_i),
        .iptal_i            (iptal_i),
        .sonuc_gecerli_o    (sonuc_gecerli_o),
        .sonuc_hazir_i      (sonuc_hazir_i),
        .bolum_o            (bolum_o),
        .kalan_o            (kalan_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: integer division truncating toward zero, remainder with dividend sign.
    function automatic void ref_div(input logic [31:0] a, input logic sa,
                                    input logic [31:0] b, input logic sb,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output int lat);
        longint av, bv, qv, rv;
        av = sa ? longint'($signed(a)) : longint'({32'd0, a});
        bv = sb ? longint'($signed(b)) : longint'({32'd0, b});
        if (bv == 0) begin
            q   = 32'hFFFF_FFFF;
            r   = a;
            lat = 1;
        end else begin
            qv  = av / bv;
            rv  = av % bv;
            q   = qv[31:0];
            r   = rv[31:0];
            lat = (sa && sb && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 1 : XLEN + 2;
        end
    endfunction

    // Issue one request, check latency/results, apply 'hold' cycles of backpressure.
    task automatic run_op(input logic [31:0] a, input logic sa,
                          input logic [31:0] b, input logic sb, input int hold);
        logic [31:0] eq, er;
        int elat, lat, w;
        ref_div(a, sa, b, sb, eq, er, elat);
        w = 0;
        while (!istek_hazir_o && w < 100) begin
            step();
            w++;
        end
        check_eq("req_ready", {63'd0, istek_hazir_o}, 64'd1);
        istek_gecerli_i    = 1'b1;
        bolunen_i          = a;
        bolunen_isaretli_i = sa;
        bolen_i            = b;
        bolen_isaretli_i   = sb;
        step();
        istek_gecerli_i    = 1'b0;
        bolunen_i          = $urandom;
        bolen_i            = $urandom;
        bolunen_isaretli_i = 1'($urandom);
        bolen_isaretli_i   = 1'($urandom);
        lat = 1;
        while (!sonuc_gecerli_o && lat < 100) begin
            step();
            lat++;
        end
        check_eq("latency", 64'(lat), 64'(elat));
        check_eq("quotient", {32'd0, bolum_o}, {32'd0, eq});
        check_eq("remainder", {32'd0, kalan_o}, {32'd0, er});
        check_eq("busy_not_ready", {63'd0, istek_hazir_o}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            step();
            check_eq("hold_valid", {63'd0, sonuc_gecerli_o}, 64'd1);
            check_eq("hold_quotient", {32'd0, bolum_o}, {32'd0, eq});
            check_eq("hold_remainder", {32'd0, kalan_o}, {32'd0, er});
            check_eq("hold_not_ready", {63'd0, istek_hazir_o}, 64'd0);
        end
        sonuc_hazir_i = 1'b1;
        step();
        sonuc_hazir_i = 1'b0;
        check_eq("valid_drop", {63'd0, sonuc_gecerli_o}, 64'd0);
        check_eq("ready_after_hs", {63'd0, istek_hazir_o}, 64'd1);
        last_q = eq;
        last_r = er;
    endtask

    // Watch for a spurious result over a window of cycles.
    task automatic expect_no_valid(input string tag, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (sonuc_gecerli_o) bad++;
        end
        check_eq(tag, 64'(bad), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rsa, rsb;
        int          sel;

        rstn_i = 1'b0;
        istek_gecerli_i = 1'b0;
        bolunen_i = '0;
        bolunen_isaretli_i = 1'b0;
        bolen_i = '0;
        bolen_isaretli_i = 1'b0;
        iptal_i = 1'b0;
        sonuc_hazir_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_ready", {63'd0, istek_hazir_o}, 64'd1);
        check_eq("rst_valid", {63'd0, sonuc_gecerli_o}, 64'd0);
        check_eq("rst_quotient", {32'd0, bolum_o}, 64'd0);
        check_eq("rst_remainder", {32'd0, kalan_o}, 64'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        step();

        // Directed corner cases.
        run_op(32'd100, 1'b0, 32'd7, 1'b0, 0);
        run_op(32'hFFFF_FFF9, 1'b1, 32'd2, 1'b1, 0);
        run_op(32'd7, 1'b1, 32'hFFFF_FFFE, 1'b1, 0);
        run_op(32'h1234_5678, 1'b0, 32'd0, 1'b0, 0);
        run_op(32'h1234_5678, 1'b1, 32'd0, 1'b1, 0);
        run_op(32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(32'hDEAD_BEEF, 1'b1, 32'd13, 1'b0, 10);

        // Flush during iteration 15.
        istek_gecerli_i = 1'b1;
        bolunen_i = 32'd12345;
        bolen_i = 32'd11;
        step();
        istek_gecerli_i = 1'b0;
        repeat (15) step();
        iptal_i = 1'b1;
        step();
        iptal_i = 1'b0;
        check_eq("abort_ready", {63'd0, istek_hazir_o}, 64'd1);
        check_eq("abort_quotient", {32'd0, bolum_o}, {32'd0, last_q});
        check_eq("abort_remainder", {32'd0, kalan_o}, {32'd0, last_r});
        expect_no_valid("abort_no_valid", 40);

        // Flush together with a request in idle: request must be ignored.
        istek_gecerli_i = 1'b1;
        iptal_i = 1'b1;
        bolunen_i = 32'd50;
        bolen_i = 32'd5;
        step();
        istek_gecerli_i = 1'b0;
        iptal_i = 1'b0;
        check_eq("iptal_req_ignored", {63'd0, istek_hazir_o}, 64'd1);
        expect_no_valid("iptal_req_no_valid", 40);

        // Flush while a result is held: result dropped, outputs retained.
        istek_gecerli_i = 1'b1;
        bolunen_i = 32'd99;
        bolen_i = 32'd0;
        bolunen_isaretli_i = 1'b0;
        bolen_isaretli_i = 1'b0;
        step();
        istek_gecerli_i = 1'b0;
        check_eq("flush_res_valid", {63'd0, sonuc_gecerli_o}, 64'd1);
        iptal_i = 1'b1;
        sonuc_hazir_i = 1'b0;
        step();
        iptal_i = 1'b0;
        check_eq("flush_res_dropped", {63'd0, sonuc_gecerli_o}, 64'd0);
        check_eq("flush_res_kalan", {32'd0, kalan_o}, 64'd99);

        // Asynchronous reset in the middle of an iteration.
        istek_gecerli_i = 1'b1;
        bolunen_i = 32'd777;
        bolen_i = 32'd3;
        step();
        istek_gecerli_i = 1'b0;
        repeat (10) step();
        #2;
        rstn_i = 1'b0;
        #1;
        check_eq("mid_rst_ready", {63'd0, istek_hazir_o}, 64'd1);
        check_eq("mid_rst_valid", {63'd0, sonuc_gecerli_o}, 64'd0);
        check_eq("mid_rst_quotient", {32'd0, bolum_o}, 64'd0);
        check_eq("mid_rst_remainder", {32'd0, kalan_o}, 64'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        expect_no_valid("mid_rst_no_valid", 40);
        run_op(32'hFFFF_FFFF, 1'b0, 32'd1, 1'b0, 0);

        // Randomized operands with occasional corner values and backpressure.
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 9);
            ra  = $urandom;
            rb  = $urandom;
            rsa = 1'($urandom);
            rsb = 1'($urandom);
            case (sel)
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2, 3: rb = 32'($urandom_range(1, 20));
                4: rb = -32'($urandom_range(1, 20));
                5: rb = ra;
                default: ;
            endcase
            run_op(ra, rsa, rb, rsb, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bolucu
`default_nettype wire
